// File: rtl/wb_regfile_pkg.sv
// Shared pipeline defines for the write-back register file.
package wb_regfile_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = 5'b00000;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special registers with asynchronous clear and same-cycle write bypass.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [RegBus-1:0] hi_i,
  input  logic [RegBus-1:0] lo_i,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o
);

  logic [RegBus-1:0] hi_q;
  logic [RegBus-1:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (whilo == WriteEnable) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
    end else if (whilo == WriteEnable) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 GPR file with two bypassed read ports, plus the HI/LO register pair.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  whilo,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  re1,
  input  logic [RegAddrBus-1:0] raddr1,
  output logic [RegBus-1:0]     rdata1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata2,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o
);

  // $0 is hardwired, so storage starts at index 1.
  logic [RegBus-1:0] regs [1:RegNum-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 1; i < RegNum; i++) begin
        regs[i] <= ZeroWord;
      end
    end else if (we == WriteEnable && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = ZeroWord;
    if (rst == RstEnable) begin
      rdata1 = ZeroWord;
    end else if (raddr1 == NOPRegAddr) begin
      rdata1 = ZeroWord;
    end else if (re1 == ReadEnable && we == WriteEnable && raddr1 == waddr) begin
      rdata1 = wdata;
    end else if (re1 == ReadEnable) begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = ZeroWord;
    if (rst == RstEnable) begin
      rdata2 = ZeroWord;
    end else if (raddr2 == NOPRegAddr) begin
      rdata2 = ZeroWord;
    end else if (re2 == ReadEnable && we == WriteEnable && raddr2 == waddr) begin
      rdata2 = wdata;
    end else if (re2 == ReadEnable) begin
      rdata2 = regs[raddr2];
    end
  end

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .whilo (whilo),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule
